// File: rtl/ts_qos_selector.sv
// TS input selector: each observation window, picks the mux channel from sync presence and error counts.
// Latency: mux_sel/switch_evt update NCH+2 edges after the window terminal count; no backpressure, strobe inputs only.
// Optional QOS_HYST_EN: auto-mode switches need a HYST-count margin over the current channel.
module ts_qos_selector #(
    parameter int NCH    = 4,
    parameter int CW     = 2,
    parameter int ERRW   = 8,
    parameter int TIMERW = 20,
    parameter int HYST   = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NCH-1:0]      sync,
    input  logic [NCH*ERRW-1:0] err_count,
    input  logic                cfg_load,
    input  logic                cfg_manual,
    input  logic [CW-1:0]       cfg_manual_ch,
    input  logic [NCH*CW-1:0]   cfg_priority,
    input  logic                cfg_fallback,
    input  logic [TIMERW-1:0]   cfg_window,
    output logic [CW-1:0]       mux_sel,
    output logic                err_clr,
    output logic                switch_evt,
    output logic                no_signal,
    output logic [NCH-1:0]      signal_present,
    output logic                busy
);

    if (NCH < 2 || NCH > 16 || CW != $clog2(NCH) || HYST < 0) begin : g_param_chk
        $error("ts_qos_selector: illegal parameter combination");
    end

    function automatic logic [NCH*CW-1:0] prio_default();
        logic [NCH*CW-1:0] p;
        p = '0;
        for (int i = 0; i < NCH; i++) p[i*CW +: CW] = CW'(i);
        return p;
    endfunction

    localparam logic [NCH*CW-1:0] PRIO_RST = prio_default();

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_EVAL, S_DECIDE} state_t;

    state_t              state, state_nx;
    logic                manual_r, fallback_r;
    logic [CW-1:0]       manual_ch_r;
    logic [NCH*CW-1:0]   prio_r;
    logic [TIMERW-1:0]   window_r, win_last, wcnt;
    logic                tc;
    logic [NCH-1:0]      sticky;
    logic [NCH*ERRW-1:0] snap;
    logic                pending, start_tc, start_pend;
    logic [NCH*ERRW-1:0] ev_cnt;
    logic [NCH-1:0]      ev_pres;
    logic [CW-1:0]       eidx;
    logic                best_vld;
    logic [CW-1:0]       best_ch;
    logic [ERRW-1:0]     best_cnt;
    logic [CW-1:0]       ent;
    logic                ent_ok;
    logic [ERRW-1:0]     ent_cnt;
    logic                cur_ok, keep;
    logic [ERRW-1:0]     cur_cnt;

    assign win_last = (window_r == '0) ? '0 : window_r - TIMERW'(1);
    assign tc       = (wcnt == win_last);
    assign busy     = (state == S_EVAL) || (state == S_DECIDE);

    assign ent     = prio_r[eidx*CW +: CW];
    assign ent_ok  = ({1'b0, ent} < (CW+1)'(NCH)) && ev_pres[ent];
    assign ent_cnt = ev_cnt[ent*ERRW +: ERRW];
    assign cur_ok  = ({1'b0, mux_sel} < (CW+1)'(NCH)) && ev_pres[mux_sel];
    assign cur_cnt = ev_cnt[mux_sel*ERRW +: ERRW];

`ifdef QOS_HYST_EN
    logic [ERRW:0]   hyst_sum;
    logic [ERRW-1:0] hyst_sat;
    assign hyst_sum = {1'b0, best_cnt} + (ERRW+1)'(HYST);
    assign hyst_sat = hyst_sum[ERRW] ? '1 : hyst_sum[ERRW-1:0];
    assign keep     = cur_ok && !(hyst_sat < cur_cnt);
`else
    assign keep     = cur_ok && !fallback_r && (cur_cnt == best_cnt);
`endif

    // A queued evaluation is served before a coincident terminal count, which then re-queues.
    always_comb begin
        state_nx   = state;
        start_tc   = 1'b0;
        start_pend = 1'b0;
        case (state)
            S_IDLE:   state_nx = S_RUN;
            S_RUN: begin
                if (!manual_r) begin
                    if (pending) begin
                        state_nx   = S_EVAL;
                        start_pend = 1'b1;
                    end else if (tc) begin
                        state_nx = S_EVAL;
                        start_tc = 1'b1;
                    end
                end
            end
            S_EVAL:   if (eidx == CW'(NCH-1)) state_nx = S_DECIDE;
            S_DECIDE: state_nx = S_RUN;
            default:  state_nx = S_IDLE;
        endcase
        if (cfg_load) begin
            state_nx   = S_RUN;
            start_tc   = 1'b0;
            start_pend = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            manual_r       <= 1'b0;
            fallback_r     <= 1'b1;
            manual_ch_r    <= '0;
            prio_r         <= PRIO_RST;
            window_r       <= TIMERW'(1);
            wcnt           <= '0;
            sticky         <= '0;
            snap           <= '0;
            pending        <= 1'b0;
            ev_cnt         <= '0;
            ev_pres        <= '0;
            eidx           <= '0;
            best_vld       <= 1'b0;
            best_ch        <= '0;
            best_cnt       <= '0;
            mux_sel        <= '0;
            err_clr        <= 1'b0;
            switch_evt     <= 1'b0;
            no_signal      <= 1'b0;
            signal_present <= '0;
        end else begin
            state      <= state_nx;
            err_clr    <= cfg_load | tc;
            switch_evt <= 1'b0;

            if (cfg_load || manual_r) pending <= 1'b0;
            else if (tc && !start_tc) pending <= 1'b1;
            else if (start_pend)      pending <= 1'b0;

            if (cfg_load) begin
                manual_r    <= cfg_manual;
                manual_ch_r <= cfg_manual_ch;
                prio_r      <= cfg_priority;
                fallback_r  <= cfg_fallback;
                window_r    <= cfg_window;
                wcnt        <= '0;
                sticky      <= '0;
                mux_sel     <= cfg_manual ? cfg_manual_ch : cfg_priority[CW-1:0];
            end else begin
                // A sync in the terminal cycle already belongs to the next window.
                if (tc) begin
                    wcnt           <= '0;
                    signal_present <= sticky;
                    snap           <= err_count;
                    sticky         <= sync;
                end else begin
                    wcnt   <= wcnt + TIMERW'(1);
                    sticky <= sticky | sync;
                end

                if (start_tc || start_pend) begin
                    ev_cnt   <= start_tc ? err_count : snap;
                    ev_pres  <= start_tc ? sticky : signal_present;
                    eidx     <= '0;
                    best_vld <= 1'b0;
                    best_ch  <= '0;
                    best_cnt <= '0;
                end else if (state == S_EVAL) begin
                    eidx <= eidx + CW'(1);
                    if (ent_ok && (!best_vld || ent_cnt < best_cnt)) begin
                        best_vld <= 1'b1;
                        best_ch  <= ent;
                        best_cnt <= ent_cnt;
                    end
                end else if (state == S_DECIDE) begin
                    if (!best_vld) begin
                        no_signal <= 1'b1;
                    end else begin
                        no_signal <= 1'b0;
                        if (!keep && best_ch != mux_sel) begin
                            mux_sel    <= best_ch;
                            switch_evt <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Latched manual channel is only consumed at cfg_load time; keep it for register readback.
    logic unused_ok;
    assign unused_ok = ^manual_ch_r;

endmodule
